// File: rtl/sram_byte_fifo.sv
// sram_byte_fifo: streaming byte FIFO in front of a 1rw1r SRAM macro.
// Bytes are written through macro port 0 and read back through port 1 into
// a 2-entry output skid buffer (ob). The skid buffer hides the one-cycle
// read latency, so one push and one pop can be sustained every cycle.
//
// Handshake: a byte moves on a rising edge where valid and ready are both 1
// on that side. The producer holds in_data while in_valid is high and
// in_ready is low. out_data is stable while out_valid is high and out_ready
// is low. in_ready and out_valid never depend combinationally on their own
// partner's valid/ready.
module sram_byte_fifo #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W:0]   level,
  output logic              sram_csb0,
  output logic              sram_web0,
  output logic              sram_wmask0,
  output logic [ADDR_W-1:0] sram_addr0,
  output logic [DATA_W-1:0] sram_din0,
  output logic              sram_csb1,
  output logic [ADDR_W-1:0] sram_addr1,
  input  logic [DATA_W-1:0] sram_dout1
);

  localparam int PW = ADDR_W + 1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [ADDR_W:0]   wr_ptr;
  logic [ADDR_W:0]   rd_ptr;
  logic [ADDR_W:0]   sram_cnt;
  logic              rd_vld_q;
  logic [1:0]        ob_cnt;
  logic [DATA_W-1:0] ob0;   // oldest entry
  logic [DATA_W-1:0] ob1;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              issue;
  logic [2:0]        ob_pending;

  assign sram_cnt = wr_ptr - rd_ptr;
  assign full     = (sram_cnt == PW'(DEPTH));
  assign empty    = (sram_cnt == '0);

  // Write side: port 0 is used purely as a write port.
  assign in_ready    = rst_n & ~full;
  assign push        = in_valid & in_ready;
  assign sram_csb0   = ~push;
  assign sram_web0   = 1'b0;
  assign sram_wmask0 = 1'b1;
  assign sram_addr0  = wr_ptr[ADDR_W-1:0];
  assign sram_din0   = in_data;

  // Read side: issue a read only if ob has room for it after this cycle's
  // pop, counting the read already in flight.
  assign out_valid  = rst_n & (ob_cnt != 2'd0);
  assign out_data   = ob0;
  assign pop        = out_valid & out_ready;
  assign ob_pending = {1'b0, ob_cnt} + {2'b00, rd_vld_q} - {2'b00, pop};
  assign issue      = rst_n & ~empty & (ob_pending < 3'd2);
  assign sram_csb1  = ~issue;
  assign sram_addr1 = rd_ptr[ADDR_W-1:0];

  // Every stored byte is in SRAM, on the read bus, or in ob.
  assign level = rst_n ? (sram_cnt + PW'(rd_vld_q) + PW'(ob_cnt)) : '0;

  // Pointer and read-in-flight tracking; reset drops any in-flight read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + 1'b1;
      if (issue) rd_ptr <= rd_ptr + 1'b1;
      rd_vld_q <= issue;
    end
  end

  // Output skid buffer: capture returning read data, shift out on pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ob_cnt <= 2'd0;
      ob0    <= '0;
      ob1    <= '0;
    end else begin
      case ({pop, rd_vld_q})
        2'b11: begin
          if (ob_cnt == 2'd1) begin
            ob0 <= sram_dout1;
          end else begin
            ob0 <= ob1;
            ob1 <= sram_dout1;
          end
        end
        2'b10: begin
          ob0    <= ob1;
          ob_cnt <= ob_cnt - 2'd1;
        end
        2'b01: begin
          if (ob_cnt == 2'd0) ob0 <= sram_dout1;
          else                ob1 <= sram_dout1;
          ob_cnt <= ob_cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // ob must always have room for the read in flight.
  a_ob_room: assert property (@(posedge clk) disable iff (!rst_n)
    ({1'b0, ob_cnt} + {2'b00, rd_vld_q}) <= 3'd2);

endmodule

// File: tb/tb_sram_byte_fifo.sv
// tb_sram_byte_fifo: directed and randomized checks of sram_byte_fifo
// against a byte-queue reference model and a simple 1rw1r SRAM model.
module tb_sram_byte_fifo;

  localparam int AW    = 10;
  localparam int DW    = 8;
  localparam int DEPTH = 1024;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW:0]   level;
  logic          sram_csb0;
  logic          sram_web0;
  logic          sram_wmask0;
  logic [AW-1:0] sram_addr0;
  logic [DW-1:0] sram_din0;
  logic          sram_csb1;
  logic [AW-1:0] sram_addr1;
  logic [DW-1:0] sram_dout1;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];   // bytes accepted and not yet popped
  logic [DW-1:0] got_q[$];   // bytes popped since last reset
  int wr_count = 0;          // bytes accepted since last reset

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL global_timeout actual running required finished");
    $fatal(1, "timeout");
  end

  sram_byte_fifo #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
    .sram_addr0(sram_addr0), .sram_din0(sram_din0),
    .sram_csb1(sram_csb1), .sram_addr1(sram_addr1), .sram_dout1(sram_dout1)
  );

  // SRAM macro model: registered write on port 0, registered read on port 1.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (!sram_csb0 && !sram_web0 && sram_wmask0) mem[sram_addr0] <= sram_din0;
    if (!sram_csb1) sram_dout1 <= mem[sram_addr1];
  end

  task automatic check(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, req);
    end
  endtask

  // ---------------- scoreboard / compare process ----------------
  always @(negedge clk) begin
    logic [DW-1:0] e;
    if (!rst_n) begin
      check(level == 0, "rst_level", int'(level), 0);
      check(in_ready == 1'b0, "rst_in_ready", int'(in_ready), 0);
      check(out_valid == 1'b0, "rst_out_valid", int'(out_valid), 0);
      check(sram_csb0 == 1'b1, "rst_csb0", int'(sram_csb0), 1);
      check(sram_csb1 == 1'b1, "rst_csb1", int'(sram_csb1), 1);
      exp_q.delete();
      got_q.delete();
      wr_count = 0;
    end else begin
      check(int'(level) == exp_q.size(), "level", int'(level), exp_q.size());
      check(int'(level) <= DEPTH + 2, "level_max", int'(level), DEPTH + 2);
      if (exp_q.size() < DEPTH)
        check(in_ready == 1'b1, "in_ready_room", int'(in_ready), 1);
      if (exp_q.size() == 0)
        check(out_valid == 1'b0, "out_valid_empty", int'(out_valid), 0);
      check(sram_csb0 == !(in_valid && in_ready), "csb0", int'(sram_csb0),
            int'(!(in_valid && in_ready)));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "pop_when_empty", int'(out_data), -1);
        end else begin
          e = exp_q.pop_front();
          check(out_data == e, "out_data", int'(out_data), int'(e));
        end
        got_q.push_back(out_data);
      end
      if (in_valid && in_ready) begin
        check(int'(sram_addr0) == wr_count % DEPTH, "addr0", int'(sram_addr0), wr_count % DEPTH);
        check(sram_din0 == in_data, "din0", int'(sram_din0), int'(in_data));
        check(sram_web0 == 1'b0 && sram_wmask0 == 1'b1, "web0_wmask0",
              int'({sram_web0, sram_wmask0}), 1);
        exp_q.push_back(in_data);
        wr_count++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 3000 && exp_q.size() != 0; c++) cyc();
    repeat (3) cyc();
    check(exp_q.size() == 0, "drain_done", exp_q.size(), 0);
  endtask

  initial begin
    logic [DW-1:0] t1_exp [3];
    int n;
    int pushed;
    bit done;
    t1_exp[0] = 8'h55; t1_exp[1] = 8'h44; t1_exp[2] = 8'h33;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;

    // Test 1: three bytes, 3-edge latency, order and addresses.
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h55;
    #1 check(sram_addr0 == 0, "t1_addr_0", int'(sram_addr0), 0);
    cyc();
    check(out_valid == 1'b0, "t1_lat_e0", int'(out_valid), 0);
    in_data = 8'h44;
    #1 check(sram_addr0 == 1, "t1_addr_1", int'(sram_addr0), 1);
    cyc();
    check(out_valid == 1'b0, "t1_lat_e1", int'(out_valid), 0);
    in_data = 8'h33;
    #1 check(sram_addr0 == 2, "t1_addr_2", int'(sram_addr0), 2);
    cyc();
    in_valid = 1'b0;
    check(out_valid == 1'b1, "t1_lat_e2", int'(out_valid), 1);
    check(out_data == 8'h55, "t1_first", int'(out_data), 8'h55);
    repeat (6) cyc();
    check(level == 0, "t1_level_zero", int'(level), 0);
    check(got_q.size() == 3, "t1_count", got_q.size(), 3);
    for (int i = 0; i < 3 && i < got_q.size(); i++)
      check(got_q[i] == t1_exp[i], "t1_order", int'(got_q[i]), int'(t1_exp[i]));

    // Test 2: fill with out_ready low; 1026 bytes fit.
    out_ready = 1'b0; n = 0; done = 1'b0;
    for (int c = 0; c < 2100; c++) begin
      in_valid = 1'b1;
      in_data  = n[7:0];
      #1;
      if (in_ready) n++;
      else done = 1'b1;
      if (done) break;
      cyc();
    end
    check(done, "t2_full_reached", int'(done), 1);
    check(n == DEPTH + 2, "t2_accepted", n, DEPTH + 2);
    check(level == DEPTH + 2, "t2_level", int'(level), DEPTH + 2);
    cyc();
    check(sram_csb0 == 1'b1, "t2_no_write_full", int'(sram_csb0), 1);

    // Test 3: pop from full; in_ready returns the cycle after the first pop.
    cyc();
    out_ready = 1'b1;
    #1;
    check(in_ready == 1'b0, "t3_ready_at_pop", int'(in_ready), 0);
    check(out_valid == 1'b1, "t3_valid_at_pop", int'(out_valid), 1);
    cyc();
    check(in_ready == 1'b1, "t3_ready_after_pop", int'(in_ready), 1);
    for (int i = 0; i < 60; i++) begin
      in_valid = 1'b1;
      in_data  = n[7:0];
      #1;
      if (in_ready) n++;
      check(out_valid == 1'b1, "t3_stream_valid", int'(out_valid), 1);
      cyc();
    end
    drain();

    // Test 4: randomized traffic, 3000 bytes, across pointer wraps.
    pushed = 0;
    for (int c = 0; c < 20000 && pushed < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = DW'($urandom);
      out_ready = ((c / 1500) % 2 == 0) ? ($urandom_range(0, 7) == 0)
                                         : ($urandom_range(0, 1) == 1);
      #1;
      if (in_valid && in_ready) pushed++;
      cyc();
    end
    check(pushed == 3000, "t4_pushed", pushed, 3000);
    drain();

    // Test 5: reset while a read is in flight; no stale byte afterwards.
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = 8'hC0 + DW'(i);
      cyc();
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    cyc();
    rst_n = 1'b1;
    #1;
    check(out_valid == 1'b0, "t5_valid_after_rst", int'(out_valid), 0);
    check(level == 0, "t5_level_after_rst", int'(level), 0);
    in_valid = 1'b1; in_data = 8'hA5;
    cyc();
    in_valid = 1'b0;
    for (int c = 0; c < 20 && got_q.size() == 0; c++) cyc();
    check(got_q.size() != 0, "t5_output_seen", got_q.size(), 1);
    if (got_q.size() != 0)
      check(got_q[0] == 8'hA5, "t5_first_byte", int'(got_q[0]), 8'hA5);
    drain();

    // Test 6: level held at 1 with matched push/pop.
    in_valid = 1'b1; in_data = 8'h3C;
    cyc();
    in_valid = 1'b0;
    for (int c = 0; c < 10 && !out_valid; c++) cyc();
    check(out_valid == 1'b1, "t6_valid", int'(out_valid), 1);
    check(out_data == 8'h3C, "t6_first", int'(out_data), 8'h3C);
    for (int i = 0; i < 100; i++) begin
      in_valid = out_valid;
      in_data  = DW'($urandom);
      #1;
      check(level == 1, "t6_level", int'(level), 1);
      cyc();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_byte_fifo.md
Name: sram_byte_fifo

Overview:
Streaming byte FIFO controller for the Ethernet datapath. It acts as the initiator for one sky130_sram_1kbyte_1rw1r_8x1024_8 macro: incoming bytes are written through port 0 (rw), and outgoing bytes are read through port 1 (r). It sits between the MAC receive path and downstream consumers, and buffers up to DEPTH bytes in SRAM plus 2 bytes in an output skid buffer.

Parameters:
ADDR_W, 10, SRAM address width
DATA_W, 8, byte width (must match macro)
DEPTH, 1024, SRAM entries (= 2**ADDR_W)

Ports:
clk  in  1  single clock; also drives the macro's clk0/clk1
rst_n  in  1  synchronous active-low reset
in_valid  in  1  input byte valid
in_ready  out  1  FIFO can accept
in_data  in  DATA_W  input byte
out_valid  out  1  output byte valid
out_ready  in  1  consumer accepts
out_data  out  DATA_W  output byte
level  out  ADDR_W+1  bytes stored (SRAM + in-flight + skid)
sram_csb0  out  1  port0 chip select, active low
sram_web0  out  1  port0 write enable, active low
sram_wmask0  out  1  port0 write mask
sram_addr0  out  ADDR_W  port0 address
sram_din0  out  DATA_W  port0 write data
sram_csb1  out  1  port1 chip select, active low
sram_addr1  out  ADDR_W  port1 address
sram_dout1  in  DATA_W  port1 read data

Behaviour:
- Clock and reset: one clock domain; reset is synchronous and active-low.
- State: wr_ptr and rd_ptr, each ADDR_W+1 bits with a wrap bit; rd_vld_q, 1 bit, marks a read in flight; ob, a 2-entry output buffer with count ob_cnt 0..2.
- SRAM occupancy: sram_cnt = wr_ptr - rd_ptr, modulo 2**(ADDR_W+1).
  - empty when sram_cnt == 0.
  - full when sram_cnt == DEPTH.
- Write side (combinational outputs):
  - in_ready = rst_n & !full.
  - push = in_valid & in_ready.
  - sram_csb0 = !push; sram_web0 = 0; sram_wmask0 = 1.
  - sram_addr0 = wr_ptr[ADDR_W-1:0]; sram_din0 = in_data.
  - wr_ptr increments on the edge where push is sampled.
- Port 0 is write-only. A write and a read never target an uncommitted address, because reads only use addresses below wr_ptr as registered.
- Read side:
  - pop = out_valid & out_ready.
  - issue = rst_n & !empty & ((ob_cnt + rd_vld_q - pop) < 2).
  - sram_csb1 = !issue; sram_addr1 = rd_ptr[ADDR_W-1:0].
  - rd_ptr increments on the issue edge; rd_vld_q <= issue.
- Read latency: sram_dout1 is valid in the cycle after the issue edge. When rd_vld_q = 1, the byte is written into ob at the next edge.
- ob is FIFO-ordered.
  - out_data = oldest ob entry; out_valid = (ob_cnt != 0).
  - A simultaneous pop and capture in the same cycle leaves ob_cnt unchanged and preserves order.
- Invariant: ob_cnt + rd_vld_q <= 2. Any violation is an assertion failure.
- Throughput: one push and one pop per cycle are sustained indefinitely when the FIFO is non-empty and not full.
- Latency: a byte pushed at edge E0 into an empty FIFO is issued at E1, captured at E2, and out_valid goes high after E2 (3 edges).
- level = sram_cnt + rd_vld_q + ob_cnt. Maximum is DEPTH + 2.
- Full boundary:
  - in_ready deasserts only on SRAM full; ob can still hold 2 extra bytes.
  - A pop while full does not raise in_ready until the resulting read issues (next cycle).
- Wrap-around: address bits wrap 1023 -> 0, and the wrap bit toggles. Ordering is preserved across the wrap.
- Simultaneous push on an empty FIFO: the byte is not readable in the same cycle. It is issued next cycle at the earliest.
- Reset (rst_n = 0 sampled at an edge):
  - wr_ptr = rd_ptr = 0; rd_vld_q = 0; ob_cnt = 0; stored data is discarded.
  - While rst_n = 0: in_ready = 0, out_valid = 0, level = 0, sram_csb0 = 1, sram_csb1 = 1.
  - Reset asserted mid-stream drops the in-flight read data; no stale byte appears after reset.
- out_data is don't-care when out_valid = 0.

Test Plan:
1. Reset, then push 0x55, 0x44, 0x33 on consecutive cycles with out_ready=1 -> sram writes at addr0 = 0, 1, 2; out_valid first high 3 edges after the first push; outputs 0x55, 0x44, 0x33 in order; level returns to 0.
2. out_ready=0; push bytes 0..1023 (value = addr mod 256) -> in_ready low after the 1024th push minus the 2 bytes moved to ob (1026 accepted total); level = 1026; no SRAM write while full.
3. From the full state, out_ready=1 continuously while pushing -> one byte out per cycle, in order, no drops or duplicates; in_ready reasserts one cycle after the first pop.
4. Stream 3000 bytes with pseudo-random in_valid and out_ready -> output sequence equals input sequence across pointer wrap; level never exceeds 1026; ob_cnt + rd_vld_q <= 2 always.
5. Push 10 bytes, assert rst_n=0 for 1 cycle while a read is in flight -> out_valid=0, level=0, csb0/csb1 high during reset; the next pushed byte 0xA5 is the first byte output.
6. Simultaneous push and pop with level = 1 held for 100 cycles -> level stays 1, data stays in order.
